tone_sequencer: RTL and testbench

Queued, parametrised successor of the single-note square-wave tone generator. It accepts note commands through a valid/ready port into a DEPTH-entry FIFO. Each command carries a note (do..si or rest), an octave (low/mid/high) and a duration in ticks. Commands play back-to-back as a square wave on pwm, with a programmable silent gap after each note. It sits between the keyboard/song-ROM logic and the buzzer pin.

---
 rtl/tone_sequencer.sv | 147 ++++++++++++++
 tb/tb_tone_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// tone_sequencer: queued square-wave note player with per-note duration and trailing silent gap
module tone_sequencer #(
   parameter int CLK_HZ    = 100_000_000,
   parameter int TICK_HZ   = 1000,
   parameter int DUR_W     = 16,
   parameter int DEPTH     = 4,
   parameter int GAP_TICKS = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_note,
   input  logic [1:0]       cmd_oct,
   input  logic [DUR_W-1:0] cmd_dur,
   input  logic             abort,
   output logic             pwm,
   output logic             busy,
   output logic             note_done
);
   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int DIV_W    = $clog2(TICK_DIV);
   localparam int AW       = $clog2(DEPTH);
   localparam int EW       = 5 + DUR_W;

   typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

   state_t           state_q, state_d;
   logic [EW-1:0]    mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [17:0]      hp_q, hp_d, tone_q, tone_d, base, head_hp;
   logic [DUR_W-1:0] rem_q, rem_d, head_dur;
   logic [DIV_W-1:0] div_q, div_d;
   logic             silent_q, silent_d, pwm_q, pwm_d;
   logic [2:0]       head_note;
   logic [1:0]       head_oct;
   logic             push, pop, tick, wrap;

   assign cmd_ready = (cnt_q != (AW+1)'(DEPTH)) && !abort;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state_q == IDLE || state_q == DONE) && (cnt_q != '0) && !abort;
   assign {head_note, head_oct, head_dur} = mem_q[rd_q];
   assign tick      = div_q == DIV_W'(TICK_DIV - 1);
   assign wrap      = tone_q == hp_q - 18'd1;
   assign pwm       = pwm_q;
   assign busy      = state_q != IDLE || cnt_q != '0;
   assign note_done = state_q == DONE;

   // Mid-octave half periods at 100 MHz; other octaves are a shift away
   always_comb begin
      base = 18'd0;
      case (head_note)
         3'd1: base = 18'd95602;
         3'd2: base = 18'd85179;
         3'd3: base = 18'd75873;
         3'd4: base = 18'd71633;
         3'd5: base = 18'd63776;
         3'd6: base = 18'd56818;
         3'd7: base = 18'd50607;
         default: base = 18'd0;
      endcase
   end

   assign head_hp = head_oct == 2'd0 ? base << 1 : head_oct == 2'd2 ? base >> 1 : base;

   always_comb begin
      state_d  = state_q;
      wr_d     = push ? wr_q + 1'b1 : wr_q;
      rd_d     = pop ? rd_q + 1'b1 : rd_q;
      cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      hp_d     = pop ? head_hp : hp_q;
      silent_d = pop ? (head_note == 3'd0 || head_oct == 2'd3) : silent_q;
      rem_d    = pop ? head_dur : rem_q;
      div_d    = div_q;
      tone_d   = tone_q;
      pwm_d    = pwm_q;
      case (state_q)
         IDLE: state_d = pop ? LOAD : IDLE;
         LOAD: begin
            tone_d  = '0;
            div_d   = '0;
            pwm_d   = 1'b0;
            state_d = rem_q == '0 ? DONE : PLAY;
         end
         PLAY: begin
            div_d  = tick ? '0 : div_q + 1'b1;
            tone_d = wrap ? '0 : tone_q + 18'd1;
            pwm_d  = pwm_q ^ (wrap && !silent_q);
            if (tick) begin
               rem_d = rem_q - 1'b1;
               if (rem_q == DUR_W'(1)) begin
                  pwm_d   = 1'b0;
                  rem_d   = DUR_W'(GAP_TICKS);
                  state_d = GAP_TICKS == 0 ? DONE : GAP;
               end
            end
         end
         GAP: begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
               rem_d   = rem_q - 1'b1;
               state_d = rem_q == DUR_W'(1) ? DONE : GAP;
            end
         end
         DONE: state_d = pop ? LOAD : IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d = IDLE;
         wr_d    = '0;
         rd_d    = '0;
         cnt_d   = '0;
         pwm_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         wr_q     <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         hp_q     <= '0;
         silent_q <= 1'b0;
         rem_q    <= '0;
         div_q    <= '0;
         tone_q   <= '0;
         pwm_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         hp_q     <= hp_d;
         silent_q <= silent_d;
         rem_q    <= rem_d;
         div_q    <= div_d;
         tone_q   <= tone_d;
         pwm_q    <= pwm_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= {cmd_note, cmd_oct, cmd_dur};
   end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: scoreboard bench; a timing model predicts pwm edges and note_done pulses per accepted command
module tb_tone_sequencer;
   localparam int TD = 10;
   localparam int GT = 2;
   localparam int MID [8] = '{0, 95602, 85179, 75873, 71633, 63776, 56818, 50607};
   localparam int RISE = 1, FALL = 2, DONE_EV = 3;

   typedef struct {int kind; int cyc;} evt_t;

   logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, abort = 1'b0;
   logic [2:0]  cmd_note = '0;
   logic [1:0]  cmd_oct = '0;
   logic [15:0] cmd_dur = '0;
   logic        cmd_ready, pwm, busy, note_done, pwm_prev = 1'b0;
   int          cyc = 0, n_checks = 0, n_fail = 0, last_done = -100, last_acc = 0;
   evt_t        exp_q [$];
   int          done_hist [$];

   tone_sequencer #(.CLK_HZ(100_000_000), .TICK_HZ(10_000_000), .DUR_W(16), .DEPTH(4), .GAP_TICKS(GT)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_note(cmd_note),
      .cmd_oct(cmd_oct), .cmd_dur(cmd_dur), .abort(abort), .pwm(pwm), .busy(busy), .note_done(note_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic got_evt(input int kind);
      evt_t e;
      if (exp_q.size() == 0) check("evt_pending", exp_q.size(), 1);
      else begin
         e = exp_q.pop_front();
         check("evt_kind", kind, e.kind);
         check("evt_cycle", cyc, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (pwm !== pwm_prev) got_evt(pwm ? RISE : FALL);
         if (note_done) got_evt(DONE_EV);
      end
      pwm_prev = pwm;
   end

   // Command accepted at edge n: play entry, pwm toggles and done pulse predicted
   task automatic model(input int n, input int note, input int oct, input int dur);
      int e, play, hp, d;
      logic lvl;
      e = (n + 2 > last_done + 2) ? n + 2 : last_done + 2;
      if (dur == 0) d = e;
      else begin
         play = dur * TD;
         lvl = 1'b0;
         hp = oct == 0 ? MID[note] * 2 : oct == 2 ? MID[note] / 2 : MID[note];
         if (note != 0 && oct != 3)
            for (int k = 1; k * hp < play; k++) begin
               lvl = !lvl;
               exp_q.push_back('{lvl ? RISE : FALL, e + k * hp});
            end
         if (lvl) exp_q.push_back('{FALL, e + play});
         d = e + play + GT * TD;
      end
      exp_q.push_back('{DONE_EV, d});
      last_done = d;
      done_hist.push_back(d);
   endtask

   task automatic send(input int note, input int oct, input int dur);
      int w;
      w = 0;
      @(negedge clk);
      cmd_note = 3'(note);
      cmd_oct = 2'(oct);
      cmd_dur = 16'(dur);
      cmd_valid = 1'b1;
      while (!cmd_ready && w < 5000) begin
         @(negedge clk);
         w++;
      end
      if (!cmd_ready) check("push_timeout", w, 0);
      else begin
         last_acc = cyc + 1;
         model(last_acc, note, oct, dur);
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int bound);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(negedge clk);
         #1 n++;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
      @(negedge clk);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_pwm"}, pwm, 0);
   endtask

   task automatic idle_flags(input string tag);
      check({tag, "_pwm"}, pwm, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_ready"}, cmd_ready, 1);
      check({tag, "_done"}, note_done, 0);
   endtask

   initial begin
      int idx;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle_flags("reset");
      repeat (200) @(negedge clk);
      idle_flags("idle200");

      send(6, 2, 5700);
      check("play_busy", busy, 1);
      wait_idle("la_high", 70000);

      send(1, 0, 1);
      wait_idle("do_low", 1000);

      idx = done_hist.size();
      for (int i = 0; i < 5; i++) send(i + 1, 1, 50 - 8 * i);
      @(negedge clk);
      check("full_ready", cmd_ready, 0);
      check("full_busy", busy, 1);
      send(7, 1, 50);
      check("stall_release", last_acc, done_hist[idx] + 2);
      wait_idle("burst", 5000);

      send(0, 1, 10);
      send(3, 3, 5);
      send(2, 1, 0);
      wait_idle("silent", 1000);

      send(5, 1, 100);
      send(2, 1, 100);
      send(3, 1, 100);
      repeat (150) @(negedge clk);
      check("pre_abort_busy", busy, 1);
      abort = 1'b1;
      cmd_note = 3'd4;
      cmd_oct = 2'd1;
      cmd_dur = 16'd3;
      cmd_valid = 1'b1;
      #1 check("abort_ready", cmd_ready, 0);
      @(posedge clk);
      #1 abort = 1'b0;
      cmd_valid = 1'b0;
      exp_q.delete();
      last_done = -100;
      @(negedge clk);
      idle_flags("abort");
      repeat (300) @(negedge clk);

      send(4, 1, 100);
      repeat (50) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 exp_q.delete();
      last_done = -100;
      @(negedge clk);
      rst = 1'b0;
      idle_flags("mid_reset");
      repeat (200) @(negedge clk);
      check("final_queue", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
